w_fsm_array: RTL and testbench



---
 rtl/w_fsm_array.sv | 76 +++++++
 tb/tb_w_fsm_array.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/w_fsm_array.sv
// Multi-channel six-state w-sequence Moore FSM with per-channel enable,
// z rising-edge pulses and saturating z-high cycle counters.
module w_fsm_array #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       w,
    input  logic                      clr_cnt,
    output logic [CHANNELS-1:0]       z,
    output logic                      z_any,
    output logic [CHANNELS-1:0]       z_rise,
    output logic [CHANNELS*CNT_W-1:0] z_cnt
);

    typedef enum logic [2:0] {
        S_A = 3'd0,
        S_B = 3'd1,
        S_C = 3'd2,
        S_D = 3'd3,
        S_E = 3'd4,
        S_F = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state;
        state_t           state_nxt;
        logic             z_prev;
        logic [CNT_W-1:0] cnt;

        // Unused codes fall to A even while the channel is disabled.
        always_comb begin
            state_nxt = S_A;
            case (state)
                S_A:     state_nxt = w[i] ? S_A : S_B;
                S_B:     state_nxt = w[i] ? S_D : S_C;
                S_C:     state_nxt = w[i] ? S_D : S_E;
                S_D:     state_nxt = w[i] ? S_A : S_F;
                S_E:     state_nxt = w[i] ? S_D : S_E;
                S_F:     state_nxt = w[i] ? S_D : S_C;
                default: state_nxt = S_A;
            endcase
            if (!en[i] && state <= S_F) begin
                state_nxt = state;
            end
        end

        always_ff @(posedge clk) begin
            if (!resetn) begin
                state  <= S_A;
                z_prev <= 1'b0;
                cnt    <= '0;
            end else begin
                state  <= state_nxt;
                z_prev <= z[i];
                if (clr_cnt) begin
                    cnt <= '0;
                end else if (z[i] && cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_ONE;
                end
            end
        end

        assign z[i]                      = (state == S_E) || (state == S_F);
        assign z_rise[i]                 = z[i] & ~z_prev;
        assign z_cnt[i*CNT_W +: CNT_W]   = cnt;
    end

    assign z_any = |z;

endmodule

// File: tb/tb_w_fsm_array.sv
// Scoreboard bench for w_fsm_array: directed sequences plus random traffic,
// checked against scalar reference FSMs on a default and a 2-bit-counter DUT.
module tb_w_fsm_array;

    localparam int CH = 4;

    logic        clk     = 1'b0;
    logic        resetn  = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [3:0]  en      = '0;
    logic [3:0]  w       = '0;

    logic [3:0]  z;
    logic [3:0]  z_rise;
    logic        z_any;
    logic [31:0] z_cnt;
    logic [3:0]  z_b;
    logic [3:0]  z_rise_b;
    logic        z_any_b;
    logic [7:0]  z_cnt_b;

    always #5 clk = ~clk;

    w_fsm_array #(.CHANNELS(4), .CNT_W(8)) dut (
        .clk(clk), .resetn(resetn), .en(en), .w(w), .clr_cnt(clr_cnt),
        .z(z), .z_any(z_any), .z_rise(z_rise), .z_cnt(z_cnt)
    );

    w_fsm_array #(.CHANNELS(4), .CNT_W(2)) dut_sat (
        .clk(clk), .resetn(resetn), .en(en), .w(w), .clr_cnt(clr_cnt),
        .z(z_b), .z_any(z_any_b), .z_rise(z_rise_b), .z_cnt(z_cnt_b)
    );

    typedef struct {
        int          n;
        logic [3:0]  z;
        logic [3:0]  rise;
        logic        any;
        logic [31:0] c8;
        logic [7:0]  c2;
    } frame_t;

    typedef struct {
        int    n;
        string name;
        int    ch;
        int    fld;
        int    val;
    } hchk_t;

    frame_t fq[$];
    hchk_t  hq[$];
    int     tests  = 0;
    int     fails  = 0;
    int     edge_n = 0;

    // Reference transition table, indexed A..F = 0..5
    int nxt0 [6] = '{1, 2, 4, 5, 4, 2};
    int nxt1 [6] = '{0, 3, 3, 0, 3, 3};
    int   st [CH];
    logic zp [CH];
    int   c8 [CH];
    int   c2 [CH];

    function automatic logic zf(int s);
        return (s == 4) || (s == 5);
    endfunction

    task automatic step(input logic r, input logic [3:0] e,
                        input logic [3:0] wv, input logic c);
        frame_t f;
        logic   zo;
        resetn  = r;
        en      = e;
        w       = wv;
        clr_cnt = c;
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < CH; i++) begin
            zo = zf(st[i]);
            if (!r) begin
                st[i] = 0;
                zp[i] = 1'b0;
                c8[i] = 0;
                c2[i] = 0;
            end else begin
                if (e[i]) st[i] = wv[i] ? nxt1[st[i]] : nxt0[st[i]];
                zp[i] = zo;
                if (c) begin
                    c8[i] = 0;
                    c2[i] = 0;
                end else if (zo) begin
                    if (c8[i] < 255) c8[i]++;
                    if (c2[i] < 3) c2[i]++;
                end
            end
        end
        f.n = edge_n;
        for (int i = 0; i < CH; i++) begin
            f.z[i]          = zf(st[i]);
            f.rise[i]       = zf(st[i]) & ~zp[i];
            f.c8[i*8 +: 8]  = 8'(c8[i]);
            f.c2[i*2 +: 2]  = 2'(c2[i]);
        end
        f.any = |f.z;
        fq.push_back(f);
        #1;
    endtask

    // Hand-computed check tied to the edge just issued.
    // fld: 0=z 1=z_rise 2=z_cnt (8-bit) 3=z_cnt (2-bit dut)
    task automatic hand(input string nm, input int ch,
                        input int fld, input int val);
        hchk_t h;
        h.n    = edge_n;
        h.name = nm;
        h.ch   = ch;
        h.fld  = fld;
        h.val  = val;
        hq.push_back(h);
    endtask

    task automatic chk(input string nm, input int n,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s edge %0d: got %h expected %h", nm, n, act, exp);
        end
    endtask

    frame_t      mf;
    hchk_t       mh;
    logic [31:0] mact;

    always @(negedge clk) begin
        while (fq.size() > 0) begin
            mf = fq.pop_front();
            chk("z",          mf.n, 32'(z),        32'(mf.z));
            chk("z_rise",     mf.n, 32'(z_rise),   32'(mf.rise));
            chk("z_any",      mf.n, 32'(z_any),    32'(mf.any));
            chk("z_cnt",      mf.n, z_cnt,         mf.c8);
            chk("sat_z",      mf.n, 32'(z_b),      32'(mf.z));
            chk("sat_z_rise", mf.n, 32'(z_rise_b), 32'(mf.rise));
            chk("sat_z_any",  mf.n, 32'(z_any_b),  32'(mf.any));
            chk("sat_z_cnt",  mf.n, 32'(z_cnt_b),  32'(mf.c2));
            while (hq.size() > 0 && hq[0].n == mf.n) begin
                mh = hq.pop_front();
                case (mh.fld)
                    0:       mact = 32'(z[mh.ch]);
                    1:       mact = 32'(z_rise[mh.ch]);
                    2:       mact = 32'(z_cnt[mh.ch*8 +: 8]);
                    default: mact = 32'(z_cnt_b[mh.ch*2 +: 2]);
                endcase
                chk(mh.name, mh.n, mact, 32'(mh.val));
            end
        end
    end

    initial begin
        for (int i = 0; i < CH; i++) begin
            st[i] = 0;
            zp[i] = 1'b0;
            c8[i] = 0;
            c2[i] = 0;
        end

        step(0, 4'h0, 4'h0, 1'b0);
        step(0, 4'h0, 4'h0, 1'b0);
        hand("rst_z0", 0, 0, 0);
        hand("rst_cnt0", 0, 2, 0);

        // Zero run on ch0, then 2-bit saturation and clear
        step(1, 4'b0001, 4'h0, 1'b0);
        step(1, 4'b0001, 4'h0, 1'b0);
        hand("zero_run_z0_early", 0, 0, 0);
        step(1, 4'b0001, 4'h0, 1'b0);
        hand("zero_run_z0", 0, 0, 1);
        hand("zero_run_rise0", 0, 1, 1);
        hand("zero_run_cnt0", 0, 2, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 4'b0001, 4'h0, 1'b0);
            hand("zero_run_rise0_once", 0, 1, 0);
            hand("zero_run_cnt8", 0, 2, k);
            hand("sat_cnt2", 0, 3, (k < 3) ? k : 3);
        end
        step(1, 4'b0001, 4'h0, 1'b1);
        hand("clr_cnt8", 0, 2, 0);
        hand("clr_cnt2", 0, 3, 0);
        step(1, 4'b0001, 4'h0, 1'b0);
        hand("post_clr_cnt8", 0, 2, 1);
        hand("post_clr_cnt2", 0, 3, 1);

        // F path on ch1
        step(1, 4'b0010, 4'b0000, 1'b0);
        step(1, 4'b0010, 4'b0010, 1'b0);
        step(1, 4'b0010, 4'b0000, 1'b0);
        hand("fpath_z1_F", 1, 0, 1);
        step(1, 4'b0010, 4'b0000, 1'b0);
        hand("fpath_z1_C", 1, 0, 0);
        hand("fpath_cnt1", 1, 2, 1);
        step(1, 4'b0010, 4'b0010, 1'b0);
        hand("fpath_z1_D", 1, 0, 0);

        // Enable hold on ch2 while in E
        for (int k = 0; k < 3; k++) step(1, 4'b0100, 4'b0000, 1'b0);
        hand("hold_z2_E", 2, 0, 1);
        hand("hold_cnt2_start", 2, 2, 0);
        for (int k = 1; k <= 5; k++) begin
            step(1, 4'b0000, (k % 2 == 1) ? 4'b0100 : 4'b0000, 1'b0);
            hand("hold_z2", 2, 0, 1);
            hand("hold_cnt2", 2, 2, k);
        end
        step(1, 4'b0100, 4'b0100, 1'b0);
        hand("hold_reenable_z2", 2, 0, 0);
        hand("hold_reenable_cnt2", 2, 2, 6);

        // Drive every channel into E, then reset mid-operation
        for (int k = 0; k < 4; k++) step(1, 4'b1111, 4'h0, 1'b0);
        hand("pre_rst_z3", 3, 0, 1);
        hand("pre_rst_cnt3", 3, 2, 1);
        step(0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < CH; i++) begin
            hand("mid_rst_z", i, 0, 0);
            hand("mid_rst_rise", i, 1, 0);
            hand("mid_rst_cnt", i, 2, 0);
        end
        step(1, 4'b1111, 4'h0, 1'b0);
        step(1, 4'b1111, 4'h0, 1'b0);
        hand("post_rst_z0_early", 0, 0, 0);
        step(1, 4'b1111, 4'h0, 1'b0);
        for (int i = 0; i < CH; i++) begin
            hand("post_rst_z", i, 0, 1);
            hand("post_rst_rise", i, 1, 1);
        end

        // Random independence traffic
        for (int k = 0; k < 200; k++) begin
            step(1, 4'($urandom), 4'($urandom), $urandom_range(0, 15) == 0);
        end

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", edge_n, 32'(fq.size() + hq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
